// File: rtl/rvr32_mem_arb_rr.sv
// rtl/rvr32_mem_arb_rr.sv - round-robin arbiter sharing one valid/ready memory port among NPORT requesters
// Optional transaction watchdog compiled in with ARB_TIMEOUT_EN.
module rvr32_mem_arb_rr #(
    parameter int NPORT = 3,
    parameter int TMO_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NPORT-1:0]   valid,
    input  logic [NPORT*32-1:0] addr,
    input  logic [NPORT*32-1:0] wdata,
    input  logic [NPORT*4-1:0] wstrb,
    output logic [NPORT-1:0]   ready,
    output logic [31:0]        rdata,
    output logic [NPORT-1:0]   grant,
    output logic               err,
    output logic               mem_valid,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_wstrb,
    input  logic               mem_ready,
    input  logic [31:0]        mem_rdata
);

    if (NPORT < 2 || NPORT > 8 || TMO_W < 1) begin : g_param_check
        $error("rvr32_mem_arb_rr: illegal NPORT or TMO_W");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [NPORT-1:0] grant_q, grant_nxt;
    logic [NPORT-1:0] ptr_q, ptr_nxt;
    logic [NPORT-1:0] hi_mask, req_hi, pick;
    logic             busy, g_valid, done, tmo;
    logic [31:0]      g_addr, g_wdata;
    logic [3:0]       g_wstrb;

    // ptr is one-hot on the last served port; ports above it win first, then wrap.
    assign hi_mask = ~((ptr_q << 1) - NPORT'(1));
    assign req_hi  = valid & hi_mask;

    always_comb begin
        pick = '0;
        if (|req_hi) begin
            pick = req_hi & (~req_hi + NPORT'(1));
        end else begin
            pick = valid & (~valid + NPORT'(1));
        end
    end

    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        g_wstrb = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant_q[i]) begin
                g_addr  = g_addr  | addr[32*i +: 32];
                g_wdata = g_wdata | wdata[32*i +: 32];
                g_wstrb = g_wstrb | wstrb[4*i +: 4];
            end
        end
    end

    assign busy    = (state == BUSY);
    assign g_valid = |(valid & grant_q);
    assign done    = busy & g_valid & (mem_ready | tmo);

    assign grant     = grant_q;
    assign mem_valid = busy & g_valid;
    assign mem_addr  = busy ? g_addr  : 32'h0;
    assign mem_wdata = busy ? g_wdata : 32'h0;
    assign mem_wstrb = busy ? g_wstrb : 4'h0;
    assign ready     = (done & ~rst) ? grant_q : '0;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        ptr_nxt   = ptr_q;
        case (state)
            IDLE: begin
                if (|valid) begin
                    state_nxt = BUSY;
                    grant_nxt = pick;
                end
            end
            BUSY: begin
                // A requester abandoning its request ends the transaction without moving the pointer.
                if (!g_valid) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end else if (mem_ready || tmo) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = grant_q;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr_q   <= {1'b1, {(NPORT-1){1'b0}}};
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            ptr_q   <= ptr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    // Held at zero while idle so every transaction starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst || state != BUSY) begin
            tmo_cnt <= '0;
        end else if (!mem_ready) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo   = busy & g_valid & ~mem_ready & (&tmo_cnt);
    assign err   = tmo & ~rst;
    assign rdata = tmo ? 32'hDEADBEEF : mem_rdata;
`else
    assign tmo   = 1'b0;
    assign err   = 1'b0;
    assign rdata = mem_rdata;
`endif

endmodule
